parallel_to_serial: RTL and testbench

Transmit-side framer that takes one N-bit result word from the exponentiation datapath and emits it as a byte stream to the UART transmitter, MSB byte first. It is the host-bound counterpart of the byte-assembling receiver and uses the same big-endian byte order, so a host can rebuild the word by shift-left-by-8 / OR. Sits between the modexp core's result output and the UART TX byte interface.

---
 rtl/rsa_pkg.sv | 28 ++
 rtl/parallel_to_serial.sv | 154 +++++++++++++++
 tb/tb_parallel_to_serial.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// ----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the modexp host link: the transmit framer's state
// encoding, the receiver's state encoding, and the default frame header byte.
// No ports; imported with "import rsa_pkg::*;".
// ----------------------------------------------------------------------------
package rsa_pkg;

    // Transmit framer states: waiting for a word, sending the header byte,
    // sending the data bytes MSB first.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } txState_e;

    // Byte-assembling receiver states, kept beside the transmitter's so both
    // ends of the link share one definition file.
    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_COLLECT = 2'd1,
        RX_DONE    = 2'd2
    } rxState_e;

    // Marker byte that opens every framed result word.
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

endpackage : rsa_pkg

// File: rtl/parallel_to_serial.sv
// ----------------------------------------------------------------------------
// parallel_to_serial
// Takes one N-bit result word from the exponentiation datapath and emits it
// to the UART transmitter as a byte stream, big-endian (MSB byte first),
// optionally preceded by a header byte.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   rx_valid   in   rx_word is valid
//   rx_word    in   N-bit word to send
//   rx_ready   out  block can accept a word (registered)
//   tx_byte    out  byte presented to the UART TX
//   tx_valid   out  tx_byte is valid
//   tx_ready   in   UART TX takes tx_byte this cycle
//   busy       out  a frame is in progress
//   frame_done out  one-cycle pulse after the last byte transfer
// ----------------------------------------------------------------------------
module parallel_to_serial
    import rsa_pkg::*;
#(
    parameter int         N        = 32,
    parameter int         NBYTES   = 4,
    parameter int         CNTW     = 3,
    parameter bit         HDR_EN   = 1'b1,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [N-1:0] rx_word,
    output logic         rx_ready,
    output logic [7:0]   tx_byte,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         frame_done
);

    // Parameter sanity: a word must split into whole bytes and the counter
    // must be wide enough to hold the full byte count.
    if ((N % 8) != 0 || N < 8) begin : gBadWidth
        $error("parallel_to_serial: N must be a positive multiple of 8");
    end
    if (NBYTES != N / 8) begin : gBadBytes
        $error("parallel_to_serial: NBYTES must equal N/8");
    end
    if (NBYTES >= (1 << CNTW)) begin : gBadCounter
        $error("parallel_to_serial: CNTW too narrow to hold NBYTES");
    end

    txState_e         state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [7:0]       txByte_q, txByte_d;
    logic             txValid_q, txValid_d;
    logic             rxReady_q, rxReady_d;
    logic             frameDone_q, frameDone_d;
    logic             byteXfer;

    assign byteXfer = txValid_q && tx_ready;

    // State and datapath registers. Reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            txByte_q    <= 8'h00;
            txValid_q   <= 1'b0;
            rxReady_q   <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            txByte_q    <= txByte_d;
            txValid_q   <= txValid_d;
            rxReady_q   <= rxReady_d;
            frameDone_q <= frameDone_d;
        end
    end

    // Next-state logic. The counter holds the number of data bytes still to
    // be loaded after the one currently on tx_byte; a transfer with the
    // counter at zero is therefore the last byte of the frame.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        txByte_d    = txByte_q;
        txValid_d   = txValid_q;
        rxReady_d   = rxReady_q;
        frameDone_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid && rxReady_q) begin
                    rxReady_d = 1'b0;
                    txValid_d = 1'b1;
                    if (HDR_EN) begin
                        shift_d  = rx_word;
                        cnt_d    = CNTW'(NBYTES);
                        txByte_d = HDR_BYTE;
                        state_d  = HDR;
                    end else begin
                        shift_d  = rx_word << 8;
                        cnt_d    = CNTW'(NBYTES - 1);
                        txByte_d = rx_word[N-1 -: 8];
                        state_d  = DATA;
                    end
                end else begin
                    // First edge out of reset (or any idle edge) opens the input.
                    rxReady_d = 1'b1;
                end
            end

            HDR: begin
                if (byteXfer) begin
                    txByte_d = shift_q[N-1 -: 8];
                    shift_d  = shift_q << 8;
                    cnt_d    = cnt_q - CNTW'(1);
                    state_d  = DATA;
                end
            end

            DATA: begin
                if (byteXfer) begin
                    if (cnt_q != '0) begin
                        txByte_d = shift_q[N-1 -: 8];
                        shift_d  = shift_q << 8;
                        cnt_d    = cnt_q - CNTW'(1);
                    end else begin
                        txValid_d   = 1'b0;
                        rxReady_d   = 1'b1;
                        frameDone_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_ready   = rxReady_q;
    assign tx_byte    = txByte_q;
    assign tx_valid   = txValid_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frameDone_q;

endmodule : parallel_to_serial

// File: tb/tb_parallel_to_serial.sv
// ----------------------------------------------------------------------------
// tb_parallel_to_serial
// Drives two framer instances (32-bit with header, 16-bit without) and
// compares the transmitted byte stream against a queue of bytes computed
// directly from the word: optional A5 header, then the word's bytes from
// most to least significant.
// ----------------------------------------------------------------------------
module tb_parallel_to_serial;

    logic        clk;
    logic        rst;

    logic        rxValid32, txReady32;
    logic [31:0] rxWord32;
    logic        rxReady32, txValid32, busy32, frameDone32;
    logic [7:0]  txByte32;

    logic        rxValid16, txReady16;
    logic [15:0] rxWord16;
    logic        rxReady16, txValid16, busy16, frameDone16;
    logic [7:0]  txByte16;

    int total;
    int bad;

    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];

    parallel_to_serial #(
        .N(32), .NBYTES(4), .CNTW(3), .HDR_EN(1'b1), .HDR_BYTE(8'hA5)
    ) dut32 (
        .clk(clk), .rst(rst),
        .rx_valid(rxValid32), .rx_word(rxWord32), .rx_ready(rxReady32),
        .tx_byte(txByte32), .tx_valid(txValid32), .tx_ready(txReady32),
        .busy(busy32), .frame_done(frameDone32)
    );

    parallel_to_serial #(
        .N(16), .NBYTES(2), .CNTW(3), .HDR_EN(1'b0), .HDR_BYTE(8'hA5)
    ) dut16 (
        .clk(clk), .rst(rst),
        .rx_valid(rxValid16), .rx_word(rxWord16), .rx_ready(rxReady16),
        .tx_byte(txByte16), .tx_valid(txValid16), .tx_ready(txReady16),
        .busy(busy16), .frame_done(frameDone16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output selectors: sel=0 picks the 32-bit instance, sel=1 the 16-bit one.
    function automatic logic oRxReady(input bit sel);
        return sel ? rxReady16 : rxReady32;
    endfunction
    function automatic logic oTxValid(input bit sel);
        return sel ? txValid16 : txValid32;
    endfunction
    function automatic logic [7:0] oTxByte(input bit sel);
        return sel ? txByte16 : txByte32;
    endfunction
    function automatic logic oBusy(input bit sel);
        return sel ? busy16 : busy32;
    endfunction
    function automatic logic oDone(input bit sel);
        return sel ? frameDone16 : frameDone32;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [31:0] w, input logic r);
        if (sel) begin
            rxValid16 = v; rxWord16 = w[15:0]; txReady16 = r;
        end else begin
            rxValid32 = v; rxWord32 = w; txReady32 = r;
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference frame: header (32-bit instance only) then bytes MSB first.
    task automatic appendFrame(input bit sel, input logic [31:0] w);
        int nb;
        logic [31:0] t;
        nb = sel ? 2 : 4;
        if (!sel) expQ.push_back(8'hA5);
        for (int i = nb - 1; i >= 0; i--) begin
            t = w >> (8 * i);
            expQ.push_back(t[7:0]);
        end
    endtask

    // Sends one word and follows it through to frame_done.
    // mode 0: tx_ready high, 1: alternating 1,0,1,0..., 2: random.
    task automatic runFrame(input bit sel, input logic [31:0] w, input int mode, input string name);
        int cycles;
        int busyCycles;
        bit doneSeen;
        bit stalled;
        logic [7:0] heldByte;
        logic rdy;
        int n;

        expQ.delete();
        gotQ.delete();
        appendFrame(sel, w);

        cycles = 0;
        while (!oRxReady(sel) && cycles < 20) begin
            tick();
            cycles++;
        end
        total++;
        if (oRxReady(sel) !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s rx_ready_wait: got %b need 1", name, oRxReady(sel));
            return;
        end

        drive(sel, 1'b1, w, 1'b1);
        tick();
        drive(sel, 1'b0, w, 1'b1);

        total++;
        if (oTxValid(sel) !== 1'b1 || oTxByte(sel) !== expQ[0]) begin
            bad++;
            $display("[TB] FAIL %s first_byte: got valid=%b byte=%h need valid=1 byte=%h",
                     name, oTxValid(sel), oTxByte(sel), expQ[0]);
        end

        cycles = 0; busyCycles = 0; doneSeen = 0; stalled = 0; heldByte = 8'h00;
        while (cycles < 60) begin
            if (stalled) begin
                total++;
                if (oTxValid(sel) !== 1'b1 || oTxByte(sel) !== heldByte) begin
                    bad++;
                    $display("[TB] FAIL %s stall_hold: got valid=%b byte=%h need valid=1 byte=%h",
                             name, oTxValid(sel), oTxByte(sel), heldByte);
                end
            end
            if (oDone(sel) === 1'b1) begin
                doneSeen = 1;
                break;
            end
            if (oBusy(sel) === 1'b1) busyCycles++;
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = ((cycles % 2) == 0);
            else                rdy = 1'($urandom_range(0, 1));
            drive(sel, 1'b0, w, rdy);
            if (oTxValid(sel) === 1'b1 && rdy) gotQ.push_back(oTxByte(sel));
            stalled  = (oTxValid(sel) === 1'b1) && !rdy;
            heldByte = oTxByte(sel);
            tick();
            cycles++;
        end

        total++;
        if (!doneSeen) begin
            bad++;
            $display("[TB] FAIL %s frame_done_timeout: got none need pulse", name);
        end

        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++;
            $display("[TB] FAIL %s byte_count: got %0d need %0d", name, gotQ.size(), expQ.size());
        end
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (gotQ[i] !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL %s byte%0d: got %h need %h", name, i, gotQ[i], expQ[i]);
            end
        end

        total++;
        if (oRxReady(sel) !== 1'b1 || oTxValid(sel) !== 1'b0 || oBusy(sel) !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s end_state: got rx_ready=%b tx_valid=%b busy=%b need 1 0 0",
                     name, oRxReady(sel), oTxValid(sel), oBusy(sel));
        end

        if (mode == 0) begin
            total++;
            if (busyCycles != expQ.size()) begin
                bad++;
                $display("[TB] FAIL %s busy_cycles: got %0d need %0d", name, busyCycles, expQ.size());
            end
        end

        drive(sel, 1'b0, w, 1'b1);
        tick();
        total++;
        if (oDone(sel) !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s done_pulse_width: got %b need 0", name, oDone(sel));
        end
    endtask

    // Reset with no traffic and rx_valid asserted: nothing may be captured.
    task automatic test_reset();
        rst = 1'b0;
        drive(0, 1'b1, 32'hCAFEF00D, 1'b1);
        drive(1, 1'b1, 32'h0000BEEF, 1'b1);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++;
            if (oRxReady(s[0]) !== 1'b0 || oTxValid(s[0]) !== 1'b0 || oTxByte(s[0]) !== 8'h00 ||
                oBusy(s[0]) !== 1'b0 || oDone(s[0]) !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_values dut%0d: got rdy=%b val=%b byte=%h busy=%b done=%b need 0 0 00 0 0",
                         s, oRxReady(s[0]), oTxValid(s[0]), oTxByte(s[0]), oBusy(s[0]), oDone(s[0]));
            end
        end
        rst = 1'b1;
        tick();
        for (int s = 0; s < 2; s++) begin
            total++;
            if (oRxReady(s[0]) !== 1'b1 || oTxValid(s[0]) !== 1'b0 || oBusy(s[0]) !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_release dut%0d: got rdy=%b val=%b busy=%b need 1 0 0",
                         s, oRxReady(s[0]), oTxValid(s[0]), oBusy(s[0]));
            end
        end
        drive(0, 1'b0, 32'h0, 1'b1);
        drive(1, 1'b0, 32'h0, 1'b1);
        tick();
    endtask

    task automatic test_basic();
        runFrame(0, 32'hDEADBEEF, 0, "basic_deadbeef");
    endtask

    task automatic test_stall();
        runFrame(0, 32'hDEADBEEF, 1, "stall_alternate");
        runFrame(0, $urandom, 2, "stall_random");
    endtask

    // A second word held on rx_valid during a frame, including across the
    // completing transfer edge, must go out exactly once, after the first.
    task automatic test_held_word();
        int cycles;
        int dones;
        bit dropNext;
        int n;

        expQ.delete();
        gotQ.delete();
        appendFrame(0, 32'hDEADBEEF);
        appendFrame(0, 32'h12345678);

        drive(0, 1'b1, 32'hDEADBEEF, 1'b1);
        tick();
        drive(0, 1'b1, 32'h12345678, 1'b1);

        cycles = 0; dones = 0; dropNext = 0;
        while (dones < 2 && cycles < 40) begin
            if (dropNext) begin
                drive(0, 1'b0, 32'h12345678, 1'b1);
                dropNext = 0;
            end
            if (frameDone32 === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    total++;
                    if (txValid32 !== 1'b0 || rxReady32 !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL held_no_early_accept: got tx_valid=%b rx_ready=%b need 0 1",
                                 txValid32, rxReady32);
                    end
                    dropNext = 1;
                end
            end
            if (dones < 2) begin
                if (txValid32 === 1'b1) gotQ.push_back(txByte32);
                tick();
                cycles++;
            end
        end
        drive(0, 1'b0, 32'h0, 1'b1);

        total++;
        if (dones != 2) begin
            bad++;
            $display("[TB] FAIL held_frame_count: got %0d need 2", dones);
        end
        total++;
        if (gotQ.size() != expQ.size()) begin
            bad++;
            $display("[TB] FAIL held_byte_count: got %0d need %0d", gotQ.size(), expQ.size());
        end
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (gotQ[i] !== expQ[i]) begin
                bad++;
                $display("[TB] FAIL held_byte%0d: got %h need %h", i, gotQ[i], expQ[i]);
            end
        end
        tick();
    endtask

    // Reset asserted partway through a frame must clear outputs without a
    // clock edge; the following frame must start again from the header.
    task automatic test_reset_mid();
        drive(0, 1'b1, $urandom, 1'b1);
        tick();
        drive(0, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        total++;
        if (txValid32 !== 1'b0 || rxReady32 !== 1'b0 || busy32 !== 1'b0 || txByte32 !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_mid_async: got val=%b rdy=%b busy=%b byte=%h need 0 0 0 00",
                     txValid32, rxReady32, busy32, txByte32);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        total++;
        if (rxReady32 !== 1'b1 || txValid32 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_release: got rdy=%b val=%b need 1 0", rxReady32, txValid32);
        end
        runFrame(0, $urandom, 0, "after_reset");
    endtask

    task automatic test_no_header();
        runFrame(1, 32'h00000102, 0, "nohdr_0102");
        runFrame(1, 32'h0000FF00, 1, "nohdr_ff00_stall");
    endtask

    task automatic test_back_to_back();
        bit sel;
        int mode;
        for (int i = 0; i < 8; i++) begin
            sel  = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            runFrame(sel, $urandom, mode, "random_frame");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        rxValid32 = 1'b0; rxWord32 = '0; txReady32 = 1'b1;
        rxValid16 = 1'b0; rxWord16 = '0; txReady16 = 1'b1;

        test_reset();
        test_basic();
        test_stall();
        test_held_word();
        test_reset_mid();
        test_no_header();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_parallel_to_serial
